// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto a single memory controller port.
// Round-robin on ties, one access in flight, controller-side fields held from grant to grant.
module mem_port_arbiter #(
    parameter int STARTUP_CYCLES = 2,
    parameter bit FETCH_FIRST    = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ifReq,
    input  logic [31:0] ifAddr,
    output logic        ifDone,
    output logic [31:0] ifData,
    output logic        ifFault,
    input  logic        dReq,
    input  logic        dWrite,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    output logic        dDone,
    output logic [31:0] dRData,
    output logic        dFault,
    input  logic        addrVirtual,
    input  logic        execMode,
    output logic [31:0] mcRamAddress,
    output logic [31:0] mcRamIn,
    output logic        mcReadReq,
    output logic        mcWriteReq,
    output logic        mcAddrVirtual,
    output logic        mcExecMode,
    input  logic [31:0] mcRamOut,
    input  logic [1:0]  mcStatus
);

    localparam logic [1:0] MC_FAULT   = 2'd0;
    localparam logic [1:0] MC_DONE    = 2'd2;
    localparam logic [3:0] START_LAST = 4'(STARTUP_CYCLES - 1);

    typedef enum logic [2:0] {START, IDLE, ISSUE, WAIT, RESP} state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] start_cnt_reg;
    logic       last_fetch_reg;
    logic       owner_fetch_reg;
    logic       write_reg;
    logic       grant;
    logic       pick_fetch;

    // Fetch wins when alone, or on a tie when data was the last port served.
    assign pick_fetch = ifReq && (!dReq || !last_fetch_reg);
    assign grant      = (state_reg == IDLE) && (ifReq || dReq);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= START;
            start_cnt_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == START) begin
                start_cnt_reg <= start_cnt_reg + 4'd1;
            end else begin
                start_cnt_reg <= '0;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            START: if (start_cnt_reg == START_LAST) state_next = IDLE;
            IDLE:  if (grant) state_next = ISSUE;
            ISSUE: state_next = WAIT;
            WAIT:  if (mcStatus == MC_DONE || mcStatus == MC_FAULT) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = START;
        endcase
    end

    always_comb begin
        mcReadReq  = (state_reg == ISSUE) && !write_reg;
        mcWriteReq = (state_reg == ISSUE) && write_reg;
        ifDone     = (state_reg == RESP) && owner_fetch_reg;
        dDone      = (state_reg == RESP) && !owner_fetch_reg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcRamAddress    <= '0;
            mcRamIn         <= '0;
            mcAddrVirtual   <= 1'b0;
            mcExecMode      <= 1'b0;
            owner_fetch_reg <= 1'b0;
            write_reg       <= 1'b0;
            last_fetch_reg  <= ~FETCH_FIRST;
            ifData          <= '0;
            ifFault         <= 1'b0;
            dRData          <= '0;
            dFault          <= 1'b0;
        end else begin
            if (grant) begin
                mcRamAddress    <= pick_fetch ? ifAddr : dAddr;
                mcRamIn         <= (!pick_fetch && dWrite) ? dWData : 32'd0;
                mcAddrVirtual   <= addrVirtual;
                mcExecMode      <= execMode;
                owner_fetch_reg <= pick_fetch;
                write_reg       <= !pick_fetch && dWrite;
                last_fetch_reg  <= pick_fetch;
            end
            // A fault keeps the previous data word; only the fault flag moves.
            if (state_reg == WAIT) begin
                if (mcStatus == MC_DONE) begin
                    if (owner_fetch_reg) begin
                        ifData  <= mcRamOut;
                        ifFault <= 1'b0;
                    end else begin
                        dRData  <= mcRamOut;
                        dFault  <= 1'b0;
                    end
                end else if (mcStatus == MC_FAULT) begin
                    if (owner_fetch_reg) begin
                        ifFault <= 1'b1;
                    end else begin
                        dFault  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
